// File: rtl/channel_scanner.sv
// Scans a 4:1 mux one channel at a time (settle, then sample) and assembles
// a 4-bit frame delivered through a valid/ready holding register.
module channel_scanner #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       continuous,
   input  logic       abort,
   input  logic       y_in,
   output logic       s1,
   output logic       s0,
   output logic [3:0] frame_data,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       busy,
   output logic       overrun
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned CH_W  = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(3);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        part_q, part_d;
   logic [3:0]        frame_data_q, frame_data_d;
   logic              frame_valid_q, frame_valid_d;
   logic              overrun_q, overrun_d;
   logic              busy_q, busy_d;
   logic              frame_done;
   logic [3:0]        new_frame;

   // Scan sequencing and frame handoff
   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      cnt_d         = cnt_q;
      part_d        = part_q;
      frame_data_d  = frame_data_q;
      frame_valid_d = frame_valid_q;
      overrun_d     = overrun_q;
      frame_done    = 1'b0;
      new_frame     = {y_in, part_q[2:0]};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               ch_d    = '0;
               cnt_d   = '0;
               part_d  = '0;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
               ch_d    = '0;
               cnt_d   = '0;
               part_d  = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            cnt_d = '0;
            if (abort) begin
               state_d = IDLE;
               ch_d    = '0;
               part_d  = '0;
            end else if (ch_q != CH_LAST) begin
               part_d[ch_q] = y_in;
               ch_d         = ch_q + 2'd1;
               state_d      = SETTLE;
            end else begin
               frame_done = 1'b1;
               part_d     = '0;
               ch_d       = '0;
               state_d    = continuous ? SETTLE : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ch_d    = '0;
            cnt_d   = '0;
            part_d  = '0;
         end
      endcase

      // A completed frame may replace a held one only when it is being accepted
      if (frame_done) begin
         if (!frame_valid_q) begin
            frame_data_d  = new_frame;
            frame_valid_d = 1'b1;
         end else if (frame_ready) begin
            frame_data_d  = new_frame;
         end else begin
            overrun_d     = 1'b1;
         end
      end else if (frame_valid_q && frame_ready) begin
         frame_valid_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ch_q          <= '0;
         cnt_q         <= '0;
         part_q        <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         cnt_q         <= cnt_d;
         part_q        <= part_d;
         frame_data_q  <= frame_data_d;
         frame_valid_q <= frame_valid_d;
         overrun_q     <= overrun_d;
         busy_q        <= busy_d;
      end
   end

   assign s1          = ch_q[1];
   assign s0          = ch_q[0];
   assign frame_data  = frame_data_q;
   assign frame_valid = frame_valid_q;
   assign overrun     = overrun_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench for channel_scanner: timing-arithmetic reference model checked
// every cycle, plus hand-computed expectations at key points of each scenario.
module tb_channel_scanner;

   localparam int unsigned S = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       abort = 1'b0;
   logic       frame_ready = 1'b0;
   logic [3:0] mux_in = 4'b0000;
   logic       y_in;
   logic       s1, s0, frame_valid, busy, overrun;
   logic [3:0] frame_data;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   channel_scanner #(.SETTLE_CYC(S)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .abort(abort), .y_in(y_in), .s1(s1), .s0(s0),
      .frame_data(frame_data), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .busy(busy), .overrun(overrun)
   );

   // Behavioural 4:1 mux: channel a is bit 0 ... d is bit 3
   assign y_in = mux_in[{s1, s0}];

   always #5 clk = ~clk;

   // Reference: position in the scan derived from elapsed cycles since start
   bit         m_active = 1'b0;
   int         m_el = 0;
   logic [3:0] m_part = 4'b0;
   logic [3:0] m_fd = 4'b0;
   bit         m_fv = 1'b0;
   bit         m_ov = 1'b0;

   always @(posedge clk) begin
      int chn, ph;
      bit done;
      logic [3:0] fr;
      done = 1'b0;
      fr = 4'b0;
      if (rst) begin
         m_active = 1'b0; m_el = 0; m_part = 4'b0;
         m_fd = 4'b0; m_fv = 1'b0; m_ov = 1'b0;
      end else begin
         if (m_active) begin
            if (abort) begin
               m_active = 1'b0;
               m_part = 4'b0;
            end else begin
               chn = m_el / (S + 1);
               ph  = m_el % (S + 1);
               if (ph == S) begin
                  m_part[chn] = mux_in[chn];
                  if (chn == 3) begin
                     done = 1'b1;
                     fr = m_part;
                     m_part = 4'b0;
                     if (continuous) m_el = 0;
                     else m_active = 1'b0;
                  end else begin
                     m_el++;
                  end
               end else begin
                  m_el++;
               end
            end
         end else if (start) begin
            m_active = 1'b1;
            m_el = 0;
            m_part = 4'b0;
         end
         if (done) begin
            if (!m_fv) begin m_fd = fr; m_fv = 1'b1; end
            else if (frame_ready) m_fd = fr;
            else m_ov = 1'b1;
         end else if (m_fv && frame_ready) begin
            m_fv = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] outs();
      return {s1, s0, busy, frame_valid, overrun, frame_data};
   endfunction

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      logic [1:0] m_sel;
      if (chk_en) begin
         m_sel = m_active ? 2'(m_el / (S + 1)) : 2'b00;
         check("cycle_model", 32'(outs()), 32'({m_sel, m_active, m_fv, m_ov, m_fd}));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      step(2);
      chk_en = 1'b1;
      rst = 1'b0;
      check("reset_state", 32'(outs()), 32'h0);

      // Single scan a=1,b=0,c=1,d=1
      mux_in = 4'b1101;
      start = 1'b1;
      step(1);
      start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         if (k < 12) begin
            check("scan_sel", 32'({s1, s0}), 32'(k / 3));
            check("scan_busy", 32'(busy), 32'h1);
         end
         if (k == 11) check("valid_before_12", 32'(frame_valid), 32'h0);
      end
      check("single_data", 32'(frame_data), 32'hd);
      check("single_valid", 32'(frame_valid), 32'h1);
      check("single_idle", 32'({busy, s1, s0}), 32'h0);

      // Handshake
      frame_ready = 1'b1;
      step(1);
      frame_ready = 1'b0;
      check("hs_valid_clr", 32'(frame_valid), 32'h0);
      check("hs_data_hold", 32'(frame_data), 32'hd);

      // Start held high throughout a scan
      mux_in = 4'b0011;
      start = 1'b1;
      step(13);
      check("hold_data", 32'(frame_data), 32'h3);
      check("hold_idle", 32'(busy), 32'h0);
      step(1);
      check("hold_restart", 32'({busy, s1, s0}), 32'h4);
      start = 1'b0;
      abort = 1'b1;
      frame_ready = 1'b1;
      step(1);
      abort = 1'b0;
      frame_ready = 1'b0;
      check("hold_abort", 32'({busy, frame_valid, frame_data}), 32'h03);

      // Abort during channel 2 settle, then a clean frame
      mux_in = 4'b1111;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(6);
      check("abort_at_ch2", 32'({s1, s0, busy}), 32'h5);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("abort_idle", 32'({s1, s0, busy, frame_valid}), 32'h0);
      mux_in = 4'b1010;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(12);
      check("after_abort_data", 32'({frame_valid, frame_data}), 32'h1a);
      frame_ready = 1'b1;
      step(1);
      frame_ready = 1'b0;

      // Continuous scan with overrun
      mux_in = 4'b1001;
      continuous = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(12);
      check("cont_frame1", 32'({frame_valid, frame_data}), 32'h19);
      mux_in = 4'b0110;
      step(12);
      check("cont_overrun", 32'({busy, frame_valid, overrun, frame_data}), 32'h79);
      abort = 1'b1;
      continuous = 1'b0;
      step(1);
      abort = 1'b0;

      // Separate run: accept exactly on the second completion
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("rst_clears_ovr", 32'(outs()), 32'h0);
      mux_in = 4'b1001;
      continuous = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(12);
      check("cont2_frame1", 32'({frame_valid, frame_data}), 32'h19);
      mux_in = 4'b0110;
      step(11);
      frame_ready = 1'b1;
      step(1);
      frame_ready = 1'b0;
      check("cont2_replace", 32'({frame_valid, overrun, frame_data}), 32'h26);
      abort = 1'b1;
      continuous = 1'b0;
      step(1);
      abort = 1'b0;

      // Reset mid-scan with valid and overrun set
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(12);
      check("pre_rst_ovr", 32'({frame_valid, overrun, frame_data}), 32'h36);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(3);
      check("pre_rst_ch1", 32'({s1, s0}), 32'h1);
      rst = 1'b1;
      start = 1'b1;
      step(1);
      check("mid_rst", 32'(outs()), 32'h0);
      step(1);
      check("rst_ign_start", 32'(busy), 32'h0);
      rst = 1'b0;
      start = 1'b0;
      step(1);
      check("post_rst_idle", 32'(outs()), 32'h0);

      // Abort coinciding with the final sample wins over completion
      mux_in = 4'b1111;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(11);
      check("pre_last_sample", 32'({s1, s0, frame_valid}), 32'h6);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("abort_beats_sample", 32'({busy, frame_valid, frame_data}), 32'h0);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
